// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: master IDs, access size
// encoding and arbitration FSM states.
package mem_arb_pkg;

  typedef enum logic {
    MstM0 = 1'b0,
    MstM1 = 1'b1
  } master_id_e;

  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic {
    StIdle,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// Small FIFO of 1-bit owner IDs, remembering which master each accepted
// request came from so responses can be routed back in order.
module owner_fifo #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Push is refused when full even if a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory target between an instruction port (M0) and
// a data port (M1): round-robin grant with lock, in-order response routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned C_OUTSTANDING = 2,
  parameter int unsigned C_ADDR_SZ     = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic                 m0_reqready_o,
  input  logic                 m0_reqvalid_i,
  input  logic [C_ADDR_SZ-1:0] m0_reqaddr_i,
  input  logic                 m0_rspready_i,
  output logic                 m0_rspvalid_o,
  output logic                 m0_rsperr_o,
  output logic [31:0]          m0_rspdata_o,
  output logic                 m1_reqready_o,
  input  logic                 m1_reqvalid_i,
  input  logic                 m1_reqdvalid_i,
  input  logic [1:0]           m1_reqsize_i,
  input  logic [C_ADDR_SZ-1:0] m1_reqaddr_i,
  input  logic [31:0]          m1_reqdata_i,
  input  logic                 m1_rspready_i,
  output logic                 m1_rspvalid_o,
  output logic                 m1_rsperr_o,
  output logic [31:0]          m1_rspdata_o,
  input  logic                 s_reqready_i,
  output logic                 s_reqvalid_o,
  output logic                 s_reqdvalid_o,
  output logic [1:0]           s_reqsize_o,
  output logic [C_ADDR_SZ-1:0] s_reqaddr_o,
  output logic [31:0]          s_reqdata_o,
  output logic                 s_rspready_o,
  input  logic                 s_rspvalid_i,
  input  logic                 s_rsperr_i,
  input  logic [31:0]          s_rspdata_i
);

  arb_state_e state_q, state_d;
  master_id_e gnt_q, gnt_d;
  master_id_e last_q, last_d;
  master_id_e grant;
  master_id_e head;
  logic       sel_valid;
  logic       accept;
  logic       fifo_full, fifo_empty, fifo_head;
  logic       rsp_pop;
  logic       err_q, err_d;

  always_comb begin
    grant     = MstM0;
    sel_valid = 1'b0;
    state_d   = state_q;
    gnt_d     = gnt_q;
    case (state_q)
      StLocked: begin
        grant     = gnt_q;
        sel_valid = (gnt_q == MstM1) ? m1_reqvalid_i : m0_reqvalid_i;
        if (s_reqready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        if (m0_reqvalid_i && m1_reqvalid_i) begin
          grant = (last_q == MstM0) ? MstM1 : MstM0;
        end else if (m1_reqvalid_i) begin
          grant = MstM1;
        end else begin
          grant = MstM0;
        end
        sel_valid = (m0_reqvalid_i | m1_reqvalid_i) & ~fifo_full;
        if (sel_valid && !s_reqready_i) begin
          state_d = StLocked;
          gnt_d   = grant;
        end
      end
    endcase
  end

  // Request path: combinational mux of the granted master, gated by reset.
  assign s_reqvalid_o  = ~reset_i & sel_valid & ~fifo_full;
  assign s_reqdvalid_o = (grant == MstM1) ? m1_reqdvalid_i : 1'b0;
  assign s_reqsize_o   = (grant == MstM1) ? m1_reqsize_i : SizeWord;
  assign s_reqaddr_o   = (grant == MstM1) ? m1_reqaddr_i : m0_reqaddr_i;
  assign s_reqdata_o   = (grant == MstM1) ? m1_reqdata_i : 32'h0;

  assign m0_reqready_o = ~reset_i & s_reqready_i & (grant == MstM0) & ~fifo_full;
  assign m1_reqready_o = ~reset_i & s_reqready_i & (grant == MstM1) & ~fifo_full;

  assign accept = s_reqvalid_o & s_reqready_i;
  assign last_d = accept ? grant : last_q;

  owner_fifo #(
    .Depth (C_OUTSTANDING)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (accept),
    .data_i  (grant),
    .pop_i   (rsp_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = master_id_e'(fifo_head);

  // Responses with no owner on record are drained and flagged in err_q.
  assign s_rspready_o  = ~reset_i &
                         (fifo_empty | ((head == MstM1) ? m1_rspready_i : m0_rspready_i));
  assign m0_rspvalid_o = ~reset_i & s_rspvalid_i & ~fifo_empty & (head == MstM0);
  assign m1_rspvalid_o = ~reset_i & s_rspvalid_i & ~fifo_empty & (head == MstM1);
  assign rsp_pop       = s_rspvalid_i & s_rspready_o & ~fifo_empty;

  assign m0_rspdata_o = s_rspdata_i;
  assign m1_rspdata_o = s_rspdata_i;
  assign m0_rsperr_o  = s_rsperr_i;
  assign m1_rsperr_o  = s_rsperr_i;

  assign err_d = err_q | (~reset_i & s_rspvalid_i & fifo_empty);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      gnt_q   <= MstM0;
      last_q  <= MstM1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a queue-based scoreboard for
// target requests and master responses.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        m0_reqready_o, m0_reqvalid_i, m0_rspready_i, m0_rspvalid_o, m0_rsperr_o;
  logic [31:0] m0_reqaddr_i, m0_rspdata_o;
  logic        m1_reqready_o, m1_reqvalid_i, m1_reqdvalid_i, m1_rspready_i;
  logic        m1_rspvalid_o, m1_rsperr_o;
  logic [1:0]  m1_reqsize_i;
  logic [31:0] m1_reqaddr_i, m1_reqdata_i, m1_rspdata_o;
  logic        s_reqready_i, s_reqvalid_o, s_reqdvalid_o, s_rspready_o;
  logic        s_rspvalid_i, s_rsperr_i;
  logic [1:0]  s_reqsize_o;
  logic [31:0] s_reqaddr_o, s_reqdata_o, s_rspdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .C_OUTSTANDING (2),
    .C_ADDR_SZ     (32)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .m0_reqready_o  (m0_reqready_o),
    .m0_reqvalid_i  (m0_reqvalid_i),
    .m0_reqaddr_i   (m0_reqaddr_i),
    .m0_rspready_i  (m0_rspready_i),
    .m0_rspvalid_o  (m0_rspvalid_o),
    .m0_rsperr_o    (m0_rsperr_o),
    .m0_rspdata_o   (m0_rspdata_o),
    .m1_reqready_o  (m1_reqready_o),
    .m1_reqvalid_i  (m1_reqvalid_i),
    .m1_reqdvalid_i (m1_reqdvalid_i),
    .m1_reqsize_i   (m1_reqsize_i),
    .m1_reqaddr_i   (m1_reqaddr_i),
    .m1_reqdata_i   (m1_reqdata_i),
    .m1_rspready_i  (m1_rspready_i),
    .m1_rspvalid_o  (m1_rspvalid_o),
    .m1_rsperr_o    (m1_rsperr_o),
    .m1_rspdata_o   (m1_rspdata_o),
    .s_reqready_i   (s_reqready_i),
    .s_reqvalid_o   (s_reqvalid_o),
    .s_reqdvalid_o  (s_reqdvalid_o),
    .s_reqsize_o    (s_reqsize_o),
    .s_reqaddr_o    (s_reqaddr_o),
    .s_reqdata_o    (s_reqdata_o),
    .s_rspready_o   (s_rspready_o),
    .s_rspvalid_i   (s_rspvalid_i),
    .s_rsperr_i     (s_rsperr_i),
    .s_rspdata_i    (s_rspdata_i)
  );

  typedef struct {
    logic        own;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic        own;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t r;
  rsp_t p;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_req(input logic own, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] data);
    req_t e;
    e.own = own; e.wr = wr; e.sz = sz; e.addr = addr; e.data = data;
    req_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic own, input logic [31:0] data, input logic err);
    rsp_t e;
    e.own = own; e.data = data; e.err = err;
    rsp_q.push_back(e);
  endtask

  // Monitor: every target accept and every master response handshake is scored.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (s_reqvalid_o && s_reqready_i) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got addr %h, required no request", s_reqaddr_o);
        end else begin
          r = req_q.pop_front();
          if ({m1_reqready_o, s_reqdvalid_o, s_reqsize_o, s_reqaddr_o} !==
              {r.own, r.wr, r.sz, r.addr} || (r.wr && s_reqdata_o !== r.data)) begin
            errors++;
            $display("FAIL req_fields: got own=%b wr=%b sz=%b addr=%h data=%h, required own=%b wr=%b sz=%b addr=%h data=%h",
                     m1_reqready_o, s_reqdvalid_o, s_reqsize_o, s_reqaddr_o, s_reqdata_o,
                     r.own, r.wr, r.sz, r.addr, r.data);
          end
        end
      end
      if (m0_rspvalid_o && m1_rspvalid_o) begin
        checks++;
        errors++;
        $display("FAIL rsp_both_valid: got both masters valid, required one");
      end
      if ((m0_rspvalid_o && m0_rspready_i) || (m1_rspvalid_o && m1_rspready_i)) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got data %h, required no response", s_rspdata_i);
        end else begin
          p = rsp_q.pop_front();
          if ({m1_rspvalid_o, (m1_rspvalid_o ? m1_rspdata_o : m0_rspdata_o),
               (m1_rspvalid_o ? m1_rsperr_o : m0_rsperr_o)} !== {p.own, p.data, p.err}) begin
            errors++;
            $display("FAIL rsp_fields: got own=%b data=%h err=%b, required own=%b data=%h err=%b",
                     m1_rspvalid_o, (m1_rspvalid_o ? m1_rspdata_o : m0_rspdata_o),
                     (m1_rspvalid_o ? m1_rsperr_o : m0_rsperr_o), p.own, p.data, p.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] hs_vec();
    return {26'h0, s_reqvalid_o, m0_reqready_o, m1_reqready_o, s_rspready_o,
            m0_rspvalid_o, m1_rspvalid_o};
  endfunction

  task automatic clear_inputs();
    m0_reqvalid_i = 0; m0_reqaddr_i = 0; m0_rspready_i = 1;
    m1_reqvalid_i = 0; m1_reqdvalid_i = 0; m1_reqsize_i = 0; m1_reqaddr_i = 0;
    m1_reqdata_i = 0; m1_rspready_i = 1;
    s_reqready_i = 0; s_rspvalid_i = 0; s_rsperr_i = 0; s_rspdata_i = 0;
  endtask

  initial begin
    clear_inputs();
    // Reset with activity on the inputs: every handshake output must stay low.
    reset_i = 1; m0_reqvalid_i = 1; s_reqready_i = 1; s_rspvalid_i = 1;
    tick();
    @(negedge clk_i);
    check("reset_handshakes", hs_vec(), 32'h0);
    tick();
    reset_i = 0;
    clear_inputs();
    @(negedge clk_i);
    check("idle_rspready", {31'h0, s_rspready_o}, 32'h1);
    check("idle_reqvalid", {31'h0, s_reqvalid_o}, 32'h0);
    check("idle_err", {31'h0, dut.err_q}, 32'h0);

    // Both valid every cycle: grants alternate M0,M1,M0,M1, M0 first.
    tick();
    m0_reqvalid_i = 1; m0_reqaddr_i = 32'h200;
    m1_reqvalid_i = 1; m1_reqdvalid_i = 0; m1_reqsize_i = 2'b01; m1_reqaddr_i = 32'h300;
    s_reqready_i = 1;
    exp_req(0, 0, 2'b10, 32'h200, 0); exp_req(1, 0, 2'b01, 32'h300, 0);
    exp_req(0, 0, 2'b10, 32'h200, 0); exp_req(1, 0, 2'b01, 32'h300, 0);
    exp_rsp(0, 32'h11, 0); exp_rsp(1, 32'h22, 0);
    exp_rsp(0, 32'h33, 0); exp_rsp(1, 32'h44, 0);
    tick(); s_rspvalid_i = 1; s_rspdata_i = 32'h11;
    tick(); s_rspdata_i = 32'h22;
    tick(); s_rspdata_i = 32'h33;
    tick(); m0_reqvalid_i = 0; m1_reqvalid_i = 0; s_rspdata_i = 32'h44;
    tick(); s_rspvalid_i = 0; s_reqready_i = 0;

    // M1 write stalled 3 cycles; M0 arrives mid-lock and must wait.
    tick();
    m1_reqvalid_i = 1; m1_reqdvalid_i = 1; m1_reqsize_i = 2'b10;
    m1_reqaddr_i = 32'h20; m1_reqdata_i = 32'h1234;
    exp_req(1, 1, 2'b10, 32'h20, 32'h1234);
    exp_req(0, 0, 2'b10, 32'h400, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("lock_valid", {31'h0, s_reqvalid_o}, 32'h1);
      check("lock_addr", s_reqaddr_o, 32'h20);
      check("lock_data", s_reqdata_o, 32'h1234);
      check("lock_m0_ready", {31'h0, m0_reqready_o}, 32'h0);
      tick();
      m0_reqvalid_i = 1; m0_reqaddr_i = 32'h400;
    end
    s_reqready_i = 1;
    @(negedge clk_i);
    check("lock_release_m0_ready", {31'h0, m0_reqready_o}, 32'h0);
    tick(); m1_reqvalid_i = 0;
    @(negedge clk_i);
    check("after_lock_m0_ready", {31'h0, m0_reqready_o}, 32'h1);
    tick(); m0_reqvalid_i = 0;
    exp_rsp(1, 32'h5, 1); exp_rsp(0, 32'h6, 0);
    s_rspvalid_i = 1; s_rspdata_i = 32'h5; s_rsperr_i = 1;
    tick(); s_rspdata_i = 32'h6; s_rsperr_i = 0;
    tick(); s_rspvalid_i = 0;

    // Two outstanding fill the FIFO; a third request waits for one response.
    m0_reqvalid_i = 1; m0_reqaddr_i = 32'h500;
    exp_req(0, 0, 2'b10, 32'h500, 0); exp_req(0, 0, 2'b10, 32'h504, 0);
    exp_req(1, 0, 2'b00, 32'h600, 0);
    tick(); m0_reqaddr_i = 32'h504;
    tick(); m0_reqvalid_i = 0;
    m1_reqvalid_i = 1; m1_reqdvalid_i = 0; m1_reqsize_i = 2'b00; m1_reqaddr_i = 32'h600;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("full_reqvalid", {31'h0, s_reqvalid_o}, 32'h0);
      check("full_m1_ready", {31'h0, m1_reqready_o}, 32'h0);
      tick();
    end
    exp_rsp(0, 32'h77, 0);
    s_rspvalid_i = 1; s_rspdata_i = 32'h77;
    @(negedge clk_i);
    check("full_pop_no_bypass", {31'h0, s_reqvalid_o}, 32'h0);
    tick(); s_rspvalid_i = 0;
    @(negedge clk_i);
    check("after_pop_m1_ready", {31'h0, m1_reqready_o}, 32'h1);
    tick(); m1_reqvalid_i = 0;

    // Outstanding M0 then M1 with M0 not ready: response is held.
    m0_rspready_i = 0; s_rspvalid_i = 1; s_rspdata_i = 32'h88;
    exp_rsp(0, 32'h88, 0); exp_rsp(1, 32'h99, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("hold_rspready", {31'h0, s_rspready_o}, 32'h0);
      check("hold_valids", {30'h0, m0_rspvalid_o, m1_rspvalid_o}, 32'h2);
      tick();
    end
    m0_rspready_i = 1;
    tick(); s_rspdata_i = 32'h99;
    tick(); s_rspvalid_i = 0;

    // Reset with two outstanding discards them; a stray response sets err_q.
    m0_reqvalid_i = 1; m0_reqaddr_i = 32'h700;
    exp_req(0, 0, 2'b10, 32'h700, 0); exp_req(1, 0, 2'b00, 32'h704, 0);
    tick(); m0_reqvalid_i = 0;
    m1_reqvalid_i = 1; m1_reqaddr_i = 32'h704;
    tick(); m1_reqvalid_i = 0;
    reset_i = 1; m0_reqvalid_i = 1; s_rspvalid_i = 1;
    @(negedge clk_i);
    check("midreset_handshakes", hs_vec(), 32'h0);
    tick(); reset_i = 0; m0_reqvalid_i = 0; s_rspvalid_i = 0; s_reqready_i = 0;
    @(negedge clk_i);
    check("postreset_rspready", {31'h0, s_rspready_o}, 32'h1);
    check("postreset_err", {31'h0, dut.err_q}, 32'h0);
    tick(); s_rspvalid_i = 1; s_rspdata_i = 32'hBAD;
    @(negedge clk_i);
    check("stray_drain", {29'h0, m0_rspvalid_o, m1_rspvalid_o, s_rspready_o}, 32'h1);
    tick(); s_rspvalid_i = 0;
    @(negedge clk_i);
    check("stray_err", {31'h0, dut.err_q}, 32'h1);

    check("req_queue_drained", req_q.size(), 32'h0);
    check("rsp_queue_drained", rsp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
